pipeline_hazard_ctrl: RTL and testbench
=======================================

Name: pipeline_hazard_ctrl

Overview:
- Stall/flush controller for the IF/ID and ID/EX pipeline registers of the 5-stage RV32 core.
- Detects load-use hazards, taken branches/jumps resolved in EX, multi-cycle EX operations (DIV/REM) and memory wait states.
- Drives PC enable plus per-register enable/flush strobes; keeps saturating stall/flush performance counters.
- Sits beside the pipeline register bank; the register bank consumes enables (hold when 0) and flushes (load zero/NOP when 1).

Parameters:
- MC_LATENCY, 4, total cycles a multi-cycle op occupies EX; legal range 1..255.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high reset
- id_rs1  in  5  rs1 of the instruction in ID
- id_rs2  in  5  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_valid  in  1  EX holds a real instruction (0 = bubble)
- ex_rd  in  5  destination register in EX
- ex_opcode  in  7  opcode in EX; load = 7'b0000011
- ex_branch_taken  in  1  branch/jump in EX resolved taken
- ex_mc_start  in  1  EX holds a multi-cycle op; held high while the op sits in EX
- mem_wait  in  1  instruction or data memory not ready
- clr_cnt  in  1  synchronous clear of both counters
- pc_en  out  1  PC register update enable
- ifid_en  out  1  IF/ID load enable
- ifid_flush  out  1  IF/ID load NOP
- idex_en  out  1  ID/EX load enable
- idex_flush  out  1  ID/EX load bubble
- mc_busy  out  1  FSM in MC_BUSY
- stall_cycles  out  CNT_W  cycles with pc_en=0, saturating
- flush_count  out  CNT_W  branch flush events, saturating

Behaviour:
- Reset: state=RUN, mc_cnt=0, both counters 0. Reset may assert mid-operation; it aborts any MC_BUSY sequence immediately.
- While reset is high, pc_en, ifid_en and idex_en are 0; ifid_flush, idex_flush and mc_busy are 0.
- Control outputs are combinational from the current state, mc_cnt and inputs; they take effect in the same cycle (zero latency).
- Default outputs: all enables 1, all flushes 0.
- A flush overrides the corresponding enable at the register bank.
- FSM states: RUN and MC_BUSY. mc_cnt is 8 bits.
- RUN priority, highest first:
  1. mem_wait=1: all enables 0, no flushes, no state change (full freeze).
  2. ex_valid & ex_branch_taken: pc_en=1, ifid_flush=1, idex_flush=1; flush_count increments.
  3. ex_valid & ex_mc_start & MC_LATENCY>1: all enables 0; mc_cnt<=MC_LATENCY-1; go to MC_BUSY.
  4. Load-use: ex_valid & ex_opcode==load & ex_rd!=0 & ((id_use_rs1 & id_rs1==ex_rd) | (id_use_rs2 & id_rs2==ex_rd)). Result: pc_en=0, ifid_en=0, idex_flush=1. This lasts exactly one cycle because EX holds a bubble next cycle.
  5. Otherwise: default outputs.
- MC_BUSY: mc_busy=1; ex_branch_taken, ex_mc_start and load-use are ignored.
  - mc_cnt>1: all enables 0; mc_cnt decrements every cycle, including while mem_wait=1.
  - mc_cnt==1 and mem_wait=0: default outputs (release); go to RUN.
  - mc_cnt==1 and mem_wait=1: hold mc_cnt at 1, all enables 0.
  - Net effect with no mem_wait: the op occupies EX for exactly MC_LATENCY cycles (start cycle plus MC_LATENCY-1 MC_BUSY cycles).
- MC_LATENCY=1: ex_mc_start has no effect.
- x0 is never a hazard (ex_rd==0 excluded).
- Counters:
  - stall_cycles increments each non-reset cycle with pc_en=0.
  - Both counters saturate at all-ones with no wrap.
  - clr_cnt=1 zeroes both on the next edge and wins over a same-cycle increment.

Test Plan:
- Load x5 in EX, ID add uses rs2=x5 -> one cycle with pc_en=0, ifid_en=0, idex_flush=1; next cycle (ex_valid=0) defaults; stall_cycles=1.
- Load with ex_rd=0, ID uses x0 -> no stall, outputs stay at defaults.
- Taken branch in EX, mem_wait=0 -> ifid_flush=1, idex_flush=1, pc_en=1 for one cycle; flush_count=1. Same stimulus with mem_wait=1 -> full freeze, no flush, count unchanged.
- MC_LATENCY=4, ex_mc_start held -> enables 0 for 3 cycles, release on the 4th; mc_busy high for cycles 2-4; stall_cycles=3. With mem_wait high during cycles 3-5 -> release on cycle 6.
- Reset asserted in MC_BUSY with mc_cnt=2 -> state=RUN, mc_busy=0, counters 0 immediately; after release, defaults.
- Preload stall_cycles to all-ones via a long mem_wait (CNT_W=4 build, 20 cycles) -> holds at 15; clr_cnt=1 -> 0 next edge.

Source files
------------

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the IF/ID and ID/EX pipeline registers.
// Handshake note: the register bank samples the enables and flushes on the same
// clk edge they are produced for. An enable of 0 holds the register, a flush of
// 1 loads NOP/bubble and overrides the matching enable. There is no back-pressure
// from the bank, and every strobe is valid for exactly the cycle it is driven.
// FSM state is visible on mc_busy (1 = MC_BUSY, 0 = RUN).
module pipeline_hazard_ctrl #(
  parameter int unsigned MC_LATENCY = 4,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_valid,
  input  logic [4:0]       ex_rd,
  input  logic [6:0]       ex_opcode,
  input  logic             ex_branch_taken,
  input  logic             ex_mc_start,
  input  logic             mem_wait,
  input  logic             clr_cnt,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam logic [6:0] OP_LOAD    = 7'b0000011;
  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_BUSY = 1'b1;
  // With a one-cycle op there is nothing to wait for, so the FSM never leaves RUN.
  localparam bit         MC_EN      = (MC_LATENCY > 1);
  localparam logic [7:0] MC_RELOAD  = 8'(MC_LATENCY - 1);

  logic [0:0]       state_q, state_d;
  logic [7:0]       mc_cnt_q, mc_cnt_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] flush_q, flush_d;
  logic             flush_evt;
  logic             load_use;

  // Load in EX whose destination feeds an ID source operand; x0 never hazards.
  assign load_use = ex_valid && (ex_opcode == OP_LOAD) && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  // Zero-latency control decode and FSM next state.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_en    = 1'b1;
    idex_flush = 1'b0;
    mc_busy    = 1'b0;
    flush_evt  = 1'b0;
    state_d    = state_q;
    mc_cnt_d   = mc_cnt_q;
    if (reset) begin
      pc_en   = 1'b0;
      ifid_en = 1'b0;
      idex_en = 1'b0;
    end else if (state_q == ST_RUN) begin
      if (mem_wait) begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
      end else if (ex_valid && ex_branch_taken) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
        flush_evt  = 1'b1;
      end else if (ex_valid && ex_mc_start && MC_EN) begin
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        mc_cnt_d = MC_RELOAD;
        state_d  = ST_MC_BUSY;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end
    end else begin
      mc_busy = 1'b1;
      if (mc_cnt_q > 8'd1) begin
        // Countdown runs even through memory waits.
        pc_en    = 1'b0;
        ifid_en  = 1'b0;
        idex_en  = 1'b0;
        mc_cnt_d = mc_cnt_q - 8'd1;
      end else if (!mem_wait) begin
        mc_cnt_d = 8'd0;
        state_d  = ST_RUN;
      end else begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
      end
    end
  end

  // Saturating performance counters; clear beats a same-cycle increment.
  always_comb begin
    stall_d = stall_q;
    flush_d = flush_q;
    if (clr_cnt) begin
      stall_d = '0;
      flush_d = '0;
    end else begin
      if (!pc_en && (stall_q != '1)) stall_d = stall_q + 1'b1;
      if (flush_evt && (flush_q != '1)) flush_d = flush_q + 1'b1;
    end
  end

  // State, countdown and counter registers with asynchronous reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_RUN;
      mc_cnt_q <= 8'd0;
      stall_q  <= '0;
      flush_q  <= '0;
    end else begin
      state_q  <= state_d;
      mc_cnt_q <= mc_cnt_d;
      stall_q  <= stall_d;
      flush_q  <= flush_d;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_count  = flush_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Bench for pipeline_hazard_ctrl: a default build (MC_LATENCY=4, CNT_W=32) and a
// narrow build (MC_LATENCY=1, CNT_W=4) share the same stimulus.
module tb_pipeline_hazard_ctrl;

  // Control vector layout: {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mc_busy}
  localparam logic [5:0] V_DEF  = 6'b110100;
  localparam logic [5:0] V_FRZ  = 6'b000000;
  localparam logic [5:0] V_BR   = 6'b111110;
  localparam logic [5:0] V_LU   = 6'b000110;
  localparam logic [5:0] V_MCS  = 6'b000001;
  localparam logic [5:0] V_MCR  = 6'b110101;
  localparam logic [6:0] OP_LD  = 7'b0000011;
  localparam logic [6:0] OP_ALU = 7'b0110011;

  logic clk = 1'b0;
  logic reset;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic id_use_rs1, id_use_rs2, ex_valid, ex_branch_taken, ex_mc_start, mem_wait, clr_cnt;
  logic [6:0] ex_opcode;
  logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mc_busy;
  logic [31:0] stall_cycles, flush_count;
  logic s_pc_en, s_ifid_en, s_ifid_flush, s_idex_en, s_idex_flush, s_mc_busy;
  logic [3:0] s_stall_cycles, s_flush_count;

  logic [5:0]  exp_q[$];
  logic [31:0] exp_stall, exp_flush;
  int n_checks = 0;
  int n_fail   = 0;

  pipeline_hazard_ctrl #(.MC_LATENCY(4), .CNT_W(32)) u_dut (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .mem_wait(mem_wait), .clr_cnt(clr_cnt),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush), .idex_en(idex_en),
    .idex_flush(idex_flush), .mc_busy(mc_busy), .stall_cycles(stall_cycles),
    .flush_count(flush_count)
  );

  pipeline_hazard_ctrl #(.MC_LATENCY(1), .CNT_W(4)) u_small (
    .clk(clk), .reset(reset), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_valid(ex_valid),
    .ex_rd(ex_rd), .ex_opcode(ex_opcode), .ex_branch_taken(ex_branch_taken),
    .ex_mc_start(ex_mc_start), .mem_wait(mem_wait), .clr_cnt(clr_cnt),
    .pc_en(s_pc_en), .ifid_en(s_ifid_en), .ifid_flush(s_ifid_flush), .idex_en(s_idex_en),
    .idex_flush(s_idex_flush), .mc_busy(s_mc_busy), .stall_cycles(s_stall_cycles),
    .flush_count(s_flush_count)
  );

  // Clock generation
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Queue the expected control vector for this cycle, compare it mid-cycle,
  // then advance across the edge and update the counter tallies.
  task automatic cyc(input string tag, input logic [5:0] exp);
    logic [5:0] want;
    logic [5:0] got;
    exp_q.push_back(exp);
    @(negedge clk);
    want = exp_q.pop_front();
    got  = {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, mc_busy};
    check(tag, 32'(got), 32'(want));
    @(posedge clk);
    #1;
    if (reset || clr_cnt) begin
      exp_stall = 0;
      exp_flush = 0;
    end else begin
      if (!want[5] && exp_stall != 32'hffff_ffff) exp_stall++;
      if (want[3]) exp_flush++;
    end
  endtask

  task automatic idle_inputs();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
    ex_valid = 1'b0; ex_rd = 5'd0; ex_opcode = OP_ALU; ex_branch_taken = 1'b0;
    ex_mc_start = 1'b0; mem_wait = 1'b0; clr_cnt = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    exp_stall = 0;
    exp_flush = 0;
    idle_inputs();
    @(posedge clk);
    #1;
    // Reset state
    cyc("reset_ctrl", V_FRZ);
    check("reset_stall", stall_cycles, 32'd0);
    check("reset_flush", flush_count, 32'd0);
    reset = 1'b0;
    cyc("post_reset", V_DEF);

    // Load-use on rs2, then the bubble cycle
    ex_valid = 1'b1; ex_opcode = OP_LD; ex_rd = 5'd5;
    id_use_rs2 = 1'b1; id_rs2 = 5'd5; id_use_rs1 = 1'b1; id_rs1 = 5'd1;
    cyc("lu_rs2", V_LU);
    ex_valid = 1'b0;
    cyc("lu_bubble", V_DEF);
    check("lu_stall_cnt", stall_cycles, 32'd1);
    // Load-use on rs1; a matching rs that is not read is harmless
    ex_valid = 1'b1; id_use_rs2 = 1'b0; id_rs1 = 5'd5;
    cyc("lu_rs1", V_LU);
    id_use_rs1 = 1'b0;
    cyc("lu_unused_rs", V_DEF);
    // x0 destination never hazards
    ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1;
    cyc("lu_x0", V_DEF);
    idle_inputs();

    // Taken branch, then the same with a memory wait
    ex_valid = 1'b1; ex_branch_taken = 1'b1;
    cyc("branch", V_BR);
    check("branch_cnt", flush_count, 32'd1);
    mem_wait = 1'b1;
    cyc("branch_mw", V_FRZ);
    check("branch_mw_cnt", flush_count, 32'd1);
    mem_wait = 1'b0; ex_valid = 1'b0;
    cyc("branch_bubble", V_DEF);
    idle_inputs();

    // Multi-cycle op, no memory wait
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    #2;
    check("small_mc_pc_en", 32'(s_pc_en), 32'd1);
    check("small_mc_busy", 32'(s_mc_busy), 32'd0);
    cyc("mc_c1", V_FRZ);
    cyc("mc_c2", V_MCS);
    cyc("mc_c3", V_MCS);
    cyc("mc_c4", V_MCR);
    ex_mc_start = 1'b0; ex_valid = 1'b0;
    cyc("mc_after", V_DEF);
    check("mc_stall_cnt", stall_cycles, exp_stall);

    // Multi-cycle op with mem_wait in cycles 3-5 and a taken branch ignored in cycle 2
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    cyc("mcw_c1", V_FRZ);
    ex_branch_taken = 1'b1;
    cyc("mcw_c2", V_MCS);
    ex_branch_taken = 1'b0; mem_wait = 1'b1;
    cyc("mcw_c3", V_MCS);
    cyc("mcw_c4", V_MCS);
    cyc("mcw_c5", V_MCS);
    mem_wait = 1'b0;
    cyc("mcw_c6", V_MCR);
    ex_mc_start = 1'b0; ex_valid = 1'b0;
    cyc("mcw_after", V_DEF);
    check("mcw_stall_cnt", stall_cycles, exp_stall);
    check("mcw_flush_cnt", flush_count, exp_flush);

    // Reset while MC_BUSY with mc_cnt=2
    ex_valid = 1'b1; ex_mc_start = 1'b1;
    cyc("mcr_c1", V_FRZ);
    cyc("mcr_c2", V_MCS);
    reset = 1'b1;
    #1;
    check("mcr_stall_now", stall_cycles, 32'd0);
    check("mcr_flush_now", flush_count, 32'd0);
    cyc("mcr_in_reset", V_FRZ);
    reset = 1'b0;
    idle_inputs();
    cyc("mcr_release", V_DEF);
    cyc("mcr_release2", V_DEF);

    // Randomized load-use patterns against a bubble cycle
    for (int i = 0; i < 24; i++) begin
      logic [5:0] e;
      logic hz;
      ex_valid = 1'b1;
      ex_opcode = ($urandom_range(0, 3) == 0) ? OP_ALU : OP_LD;
      ex_rd = 5'($urandom_range(0, 31));
      id_use_rs1 = 1'($urandom_range(0, 1));
      id_use_rs2 = 1'($urandom_range(0, 1));
      id_rs1 = ($urandom_range(0, 1) == 1) ? ex_rd : 5'($urandom_range(0, 31));
      id_rs2 = ($urandom_range(0, 1) == 1) ? ex_rd : 5'($urandom_range(0, 31));
      hz = (ex_opcode == OP_LD) && (ex_rd != 5'd0) &&
           ((id_use_rs1 && id_rs1 == ex_rd) || (id_use_rs2 && id_rs2 == ex_rd));
      e = hz ? V_LU : V_DEF;
      cyc("rand_lu", e);
      ex_valid = 1'b0;
      cyc("rand_bubble", V_DEF);
    end
    check("rand_stall_cnt", stall_cycles, exp_stall);
    idle_inputs();

    // Counter saturation in the 4-bit build and clear priority
    clr_cnt = 1'b1;
    cyc("sat_clr", V_DEF);
    clr_cnt = 1'b0;
    mem_wait = 1'b1;
    for (int i = 0; i < 20; i++) cyc("sat_frz", V_FRZ);
    check("sat_small", 32'(s_stall_cycles), 32'd15);
    check("sat_main", stall_cycles, 32'd20);
    clr_cnt = 1'b1;
    cyc("sat_clr_wins", V_FRZ);
    check("clr_small", 32'(s_stall_cycles), 32'd0);
    check("clr_main", stall_cycles, 32'd0);
    check("clr_flush", flush_count, 32'd0);
    idle_inputs();
    cyc("final_idle", V_DEF);
    check("final_stall", stall_cycles, exp_stall);

    if (exp_q.size() != 0) check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
